// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline encodings: ALU operations, forwarding selects and
// writeback sources, used by the decoder, hazard unit and execute stage alike.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

endpackage

// File: rtl/execute_stage_if.sv
// Signal bundle between decode/hazard logic (master) and the execute stage
// (slave): decode operands and control in, hazard feedback and EX/MEM out.
interface execute_stage_if #(
  parameter int XLEN = riscv_pkg::XLEN
);

  logic            FlushE;
  logic [XLEN-1:0] RD1D, RD2D;
  logic [XLEN-1:0] PCD, PCPlus4D, ImmExtD;
  logic [4:0]      Rs1D, Rs2D, RdD;
  logic            RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]      ResultSrcD;
  logic [2:0]      ALUControlD;
  logic [1:0]      ForwardAE, ForwardBE;
  logic [XLEN-1:0] ResultW;

  logic [4:0]      Rs1E, Rs2E, RdE;
  logic            ResultSrcE0;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            RegWriteM, MemWriteM;
  logic [1:0]      ResultSrcM;
  logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]      RdM;

  modport master (
    output FlushE, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
           RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD,
           ALUControlD, ForwardAE, ForwardBE, ResultW,
    input  Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE, PCTargetE, RegWriteM,
           MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM
  );

  modport slave (
    input  FlushE, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
           RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD,
           ALUControlD, ForwardAE, ForwardBE, ResultW,
    output Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE, PCTargetE, RegWriteM,
           MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM
  );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational XLEN-bit ALU: add, sub, and, or, signed slt; unused codes give 0.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  always_comb begin
    // NOTE: default first so every path assigns Result and no latch is inferred.
    Result = '0;
    case (alu_ctrl_t'(ALUControl))
      ALU_ADD: Result = SrcA + SrcB;
      ALU_SUB: Result = SrcA - SrcB;
      ALU_AND: Result = SrcA & SrcB;
      ALU_OR:  Result = SrcA | SrcB;
      ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_stage.sv
// RISC-V execute stage: ID/EX register, operand forwarding, ALU, branch/jump
// resolution and the EX/MEM register feeding the memory stage.
module execute_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input logic           clk,
  input logic           reset,
  execute_stage_if.slave bus
);

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm_ext;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } idex_t;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc_plus4;
  } exmem_t;

  idex_t           idex;
  exmem_t          exmem;
  logic [XLEN-1:0] src_a, write_data_e, src_b, alu_result_e;
  logic            zero_e;

  // A bubble is the all-zero record: add 0+0 with no writes and no redirect.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every pipeline register samples pre-edge values.
    if (reset || bus.FlushE) begin
      idex <= '0;
    end else begin
      idex.reg_write   <= bus.RegWriteD;
      idex.mem_write   <= bus.MemWriteD;
      idex.jump        <= bus.JumpD;
      idex.branch      <= bus.BranchD;
      idex.alu_src     <= bus.ALUSrcD;
      idex.result_src  <= bus.ResultSrcD;
      idex.alu_control <= bus.ALUControlD;
      idex.rd1         <= bus.RD1D;
      idex.rd2         <= bus.RD2D;
      idex.pc          <= bus.PCD;
      idex.pc_plus4    <= bus.PCPlus4D;
      idex.imm_ext     <= bus.ImmExtD;
      idex.rs1         <= bus.Rs1D;
      idex.rs2         <= bus.Rs2D;
      idex.rd          <= bus.RdD;
    end
  end

  // Select 11 is not a legal hazard-unit output and falls back to the register.
  always_comb begin
    src_a = idex.rd1;
    case (fwd_sel_t'(bus.ForwardAE))
      FWD_MEM: src_a = exmem.alu_result;
      FWD_WB:  src_a = bus.ResultW;
      default: src_a = idex.rd1;
    endcase
  end

  always_comb begin
    write_data_e = idex.rd2;
    case (fwd_sel_t'(bus.ForwardBE))
      FWD_MEM: write_data_e = exmem.alu_result;
      FWD_WB:  write_data_e = bus.ResultW;
      default: write_data_e = idex.rd2;
    endcase
  end

  assign src_b = idex.alu_src ? idex.imm_ext : write_data_e;

  alu #(.XLEN(XLEN)) u_alu (
    .SrcA       (src_a),
    .SrcB       (src_b),
    .ALUControl (idex.alu_control),
    .Result     (alu_result_e),
    .Zero       (zero_e)
  );

  // Only beq is decoded, so a taken branch is simply a zero subtract result.
  assign bus.PCSrcE      = idex.jump | (idex.branch & zero_e);
  assign bus.PCTargetE   = idex.pc + idex.imm_ext;
  assign bus.Rs1E        = idex.rs1;
  assign bus.Rs2E        = idex.rs2;
  assign bus.RdE         = idex.rd;
  assign bus.ResultSrcE0 = idex.result_src[0];

  // EX/MEM is never flushed: a redirecting branch still retires into M.
  always_ff @(posedge clk) begin
    if (reset) begin
      exmem <= '0;
    end else begin
      exmem.reg_write  <= idex.reg_write;
      exmem.mem_write  <= idex.mem_write;
      exmem.result_src <= idex.result_src;
      exmem.alu_result <= alu_result_e;
      exmem.write_data <= write_data_e;
      exmem.rd         <= idex.rd;
      exmem.pc_plus4   <= idex.pc_plus4;
    end
  end

  assign bus.RegWriteM  = exmem.reg_write;
  assign bus.MemWriteM  = exmem.mem_write;
  assign bus.ResultSrcM = exmem.result_src;
  assign bus.ALUResultM = exmem.alu_result;
  assign bus.WriteDataM = exmem.write_data;
  assign bus.RdM        = exmem.rd;
  assign bus.PCPlus4M   = exmem.pc_plus4;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: a vector table for single instructions plus
// hand-written sequences for forwarding, flush and reset interactions.
module tb_execute_stage;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  execute_stage_if #(.XLEN(32)) bus ();

  execute_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] rd1, rd2, pc, pcp4, imm;
    logic [4:0]  rd;
    logic        regw, memw, jump, branch, alusrc;
    logic [1:0]  rsrc;
    logic [2:0]  ctrl;
    logic [1:0]  fwda, fwdb;
    logic [31:0] resw;
    logic        e_pcsrc;
    logic [31:0] e_target, e_alu, e_wd;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vec [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_d();
    bus.FlushE = 0; bus.RD1D = 0; bus.RD2D = 0; bus.PCD = 0; bus.PCPlus4D = 0;
    bus.ImmExtD = 0; bus.Rs1D = 0; bus.Rs2D = 0; bus.RdD = 0; bus.RegWriteD = 0;
    bus.MemWriteD = 0; bus.JumpD = 0; bus.BranchD = 0; bus.ALUSrcD = 0;
    bus.ResultSrcD = 0; bus.ALUControlD = 0;
  endtask

  task automatic idle_all();
    idle_d();
    bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ResultW = 0;
  endtask

  task automatic drive_d(input vec_t v);
    bus.RD1D = v.rd1; bus.RD2D = v.rd2; bus.PCD = v.pc; bus.PCPlus4D = v.pcp4;
    bus.ImmExtD = v.imm; bus.RdD = v.rd; bus.Rs1D = 5'd1; bus.Rs2D = 5'd2;
    bus.RegWriteD = v.regw; bus.MemWriteD = v.memw; bus.JumpD = v.jump;
    bus.BranchD = v.branch; bus.ALUSrcD = v.alusrc; bus.ResultSrcD = v.rsrc;
    bus.ALUControlD = v.ctrl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " RdE"}, bus.RdE, 0);
    check({tag, " Rs1E"}, bus.Rs1E, 0);
    check({tag, " Rs2E"}, bus.Rs2E, 0);
    check({tag, " ResultSrcE0"}, bus.ResultSrcE0, 0);
    check({tag, " PCSrcE"}, bus.PCSrcE, 0);
    check({tag, " PCTargetE"}, bus.PCTargetE, 0);
    check({tag, " RegWriteM"}, bus.RegWriteM, 0);
    check({tag, " MemWriteM"}, bus.MemWriteM, 0);
    check({tag, " ResultSrcM"}, bus.ResultSrcM, 0);
    check({tag, " ALUResultM"}, bus.ALUResultM, 0);
    check({tag, " WriteDataM"}, bus.WriteDataM, 0);
    check({tag, " PCPlus4M"}, bus.PCPlus4M, 0);
    check({tag, " RdM"}, bus.RdM, 0);
  endtask

  initial begin
    // rd1, rd2, pc, pcp4, imm, rd, regw, memw, jump, branch, alusrc, rsrc, ctrl,
    // fwda, fwdb, resw, e_pcsrc, e_target, e_alu, e_wd
    vec[0]  = '{32'd5, 32'd7, 0, 32'd4, 0, 5'd3, 1, 0, 0, 0, 0, 2'd0, 3'b000,
                2'd0, 2'd0, 0, 0, 0, 32'd12, 32'd7};
    vec[1]  = '{32'hFFFF_FFFE, 32'd1, 0, 0, 0, 5'd4, 1, 0, 0, 0, 0, 2'd0, 3'b001,
                2'd0, 2'd0, 0, 0, 0, 32'hFFFF_FFFD, 32'd1};
    vec[2]  = '{32'hFFFF_FFFE, 32'd1, 0, 0, 0, 5'd5, 1, 0, 0, 0, 0, 2'd0, 3'b101,
                2'd0, 2'd0, 0, 0, 0, 32'd1, 32'd1};
    vec[3]  = '{32'd1, 32'hFFFF_FFFE, 0, 0, 0, 5'd6, 1, 0, 0, 0, 0, 2'd0, 3'b101,
                2'd0, 2'd0, 0, 0, 0, 32'd0, 32'hFFFF_FFFE};
    vec[4]  = '{32'h0000_F0F0, 32'h0000_FF00, 0, 0, 0, 5'd7, 1, 0, 0, 0, 0, 2'd0, 3'b010,
                2'd0, 2'd0, 0, 0, 0, 32'h0000_F000, 32'h0000_FF00};
    vec[5]  = '{32'h0000_F0F0, 32'h0000_FF00, 0, 0, 0, 5'd8, 1, 0, 0, 0, 0, 2'd0, 3'b011,
                2'd0, 2'd0, 0, 0, 0, 32'h0000_FFF0, 32'h0000_FF00};
    vec[6]  = '{32'd3, 32'h55, 0, 0, 32'h10, 5'd0, 0, 1, 0, 0, 1, 2'd0, 3'b000,
                2'd0, 2'd0, 0, 0, 32'h10, 32'h13, 32'h55};
    vec[7]  = '{32'd8, 32'd8, 32'h100, 32'h104, 32'h20, 5'd0, 0, 0, 0, 1, 0, 2'd0, 3'b001,
                2'd0, 2'd0, 0, 1, 32'h120, 32'd0, 32'd8};
    vec[8]  = '{32'd8, 32'd9, 32'h100, 32'h104, 32'h20, 5'd0, 0, 0, 0, 1, 0, 2'd0, 3'b001,
                2'd0, 2'd0, 0, 0, 32'h120, 32'hFFFF_FFFF, 32'd9};
    vec[9]  = '{32'd1, 32'd2, 32'h200, 32'h204, 32'h40, 5'd1, 1, 0, 1, 0, 0, 2'd2, 3'b000,
                2'd0, 2'd0, 0, 1, 32'h240, 32'd3, 32'd2};
    vec[10] = '{32'd5, 32'd7, 0, 0, 0, 5'd9, 1, 0, 0, 0, 0, 2'd0, 3'b110,
                2'd0, 2'd0, 0, 0, 0, 32'd0, 32'd7};
    vec[11] = '{32'd5, 32'd7, 0, 0, 0, 5'd9, 1, 0, 0, 0, 0, 2'd0, 3'b111,
                2'd0, 2'd0, 0, 0, 0, 32'd0, 32'd7};
    vec[12] = '{32'd99, 32'd6, 0, 0, 0, 5'd10, 1, 0, 0, 0, 0, 2'd0, 3'b000,
                2'd1, 2'd0, 32'd4, 0, 0, 32'd10, 32'd6};
    vec[13] = '{32'd1, 32'd99, 0, 0, 0, 5'd11, 1, 0, 0, 0, 0, 2'd0, 3'b000,
                2'd0, 2'd1, 32'd4, 0, 0, 32'd5, 32'd4};
    vec[14] = '{32'd7, 32'd3, 0, 0, 0, 5'd12, 1, 0, 0, 0, 0, 2'd0, 3'b000,
                2'd3, 2'd3, 32'd100, 0, 0, 32'd10, 32'd3};
    vec[15] = '{32'd2, 32'd3, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'h20, 5'd13, 1, 0, 0, 0, 0, 2'd0, 3'b000,
                2'd0, 2'd0, 0, 0, 32'h10, 32'd5, 32'd3};
    vec[16] = '{32'h1000, 32'h77, 0, 0, 32'h8, 5'd14, 1, 0, 0, 0, 1, 2'd1, 3'b000,
                2'd0, 2'd0, 0, 0, 32'h8, 32'h1008, 32'h77};

    // Reset together with a flush and busy inputs: everything must read zero.
    idle_all();
    reset = 1;
    bus.FlushE = 1; bus.RD1D = 32'hDEAD; bus.RdD = 5'd7; bus.RegWriteD = 1;
    bus.MemWriteD = 1; bus.JumpD = 1; bus.ImmExtD = 32'h44; bus.PCD = 32'h80;
    step();
    step();
    idle_all();
    check_all_zero("reset");
    reset = 0;

    // Single-instruction vectors: E-side checks during EX, M-side one edge later.
    for (int i = 0; i < NVEC; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive_d(vec[i]);
      step();
      idle_d();
      bus.ForwardAE = vec[i].fwda;
      bus.ForwardBE = vec[i].fwdb;
      bus.ResultW   = vec[i].resw;
      #1;
      check({tag, " PCSrcE"}, bus.PCSrcE, vec[i].e_pcsrc);
      check({tag, " PCTargetE"}, bus.PCTargetE, vec[i].e_target);
      check({tag, " RdE"}, bus.RdE, vec[i].rd);
      check({tag, " ResultSrcE0"}, bus.ResultSrcE0, vec[i].rsrc[0]);
      step();
      bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ResultW = 0;
      check({tag, " ALUResultM"}, bus.ALUResultM, vec[i].e_alu);
      check({tag, " WriteDataM"}, bus.WriteDataM, vec[i].e_wd);
      check({tag, " RdM"}, bus.RdM, vec[i].rd);
      check({tag, " RegWriteM"}, bus.RegWriteM, vec[i].regw);
      check({tag, " MemWriteM"}, bus.MemWriteM, vec[i].memw);
      check({tag, " ResultSrcM"}, bus.ResultSrcM, vec[i].rsrc);
      check({tag, " PCPlus4M"}, bus.PCPlus4M, vec[i].pcp4);
    end

    // Back-to-back: add x1 = 4+6; add x2 = x1+x1 forwarded from ALUResultM.
    idle_all();
    bus.RD1D = 32'd4; bus.RD2D = 32'd6; bus.RdD = 5'd1; bus.RegWriteD = 1;
    step();
    bus.RD1D = 32'd77; bus.RD2D = 32'd77; bus.Rs1D = 5'd1; bus.Rs2D = 5'd1;
    bus.RdD = 5'd2;
    step();
    idle_d();
    bus.ForwardAE = 2'b10; bus.ForwardBE = 2'b10;
    #1;
    check("fwd_mem first ALUResultM", bus.ALUResultM, 32'd10);
    check("fwd_mem Rs1E", bus.Rs1E, 5'd1);
    step();
    idle_all();
    check("fwd_mem second ALUResultM", bus.ALUResultM, 32'd20);
    check("fwd_mem second WriteDataM", bus.WriteDataM, 32'd10);
    check("fwd_mem second RdM", bus.RdM, 5'd2);

    // Flush squashes an incoming load/store-like instruction.
    bus.FlushE = 1; bus.RegWriteD = 1; bus.MemWriteD = 1; bus.ResultSrcD = 2'b01;
    bus.RdD = 5'd9; bus.RD1D = 32'h123; bus.JumpD = 1; bus.PCD = 32'h40; bus.ImmExtD = 32'h4;
    step();
    idle_all();
    #1;
    check("flush RdE", bus.RdE, 0);
    check("flush ResultSrcE0", bus.ResultSrcE0, 0);
    check("flush PCSrcE", bus.PCSrcE, 0);
    check("flush PCTargetE", bus.PCTargetE, 0);
    step();
    check("flush RegWriteM", bus.RegWriteM, 0);
    check("flush MemWriteM", bus.MemWriteM, 0);
    check("flush ALUResultM", bus.ALUResultM, 0);

    // Jump in EX with FlushE: the jump retires to M, the incoming op is squashed.
    bus.JumpD = 1; bus.RegWriteD = 1; bus.RdD = 5'd1; bus.ResultSrcD = 2'b10;
    bus.PCD = 32'h40; bus.PCPlus4D = 32'h44; bus.ImmExtD = 32'h100;
    step();
    idle_d();
    bus.RegWriteD = 1; bus.MemWriteD = 1; bus.RdD = 5'd5; bus.FlushE = 1;
    #1;
    check("redirect PCSrcE", bus.PCSrcE, 1);
    check("redirect PCTargetE", bus.PCTargetE, 32'h140);
    step();
    idle_all();
    check("redirect RdM", bus.RdM, 5'd1);
    check("redirect RegWriteM", bus.RegWriteM, 1);
    check("redirect PCPlus4M", bus.PCPlus4M, 32'h44);
    check("redirect squashed RdE", bus.RdE, 0);
    step();
    check("redirect squashed RegWriteM", bus.RegWriteM, 0);
    check("redirect squashed MemWriteM", bus.MemWriteM, 0);

    // Reset with a register write in M-bound EX and a store following behind.
    bus.RegWriteD = 1; bus.RdD = 5'd3; bus.RD1D = 32'd1;
    step();
    idle_d();
    bus.MemWriteD = 1; bus.RD2D = 32'hABCD;
    step();
    idle_d();
    check("pre-reset RegWriteM", bus.RegWriteM, 1);
    reset = 1;
    step();
    reset = 0;
    check("reset store MemWriteM", bus.MemWriteM, 0);
    check("reset store RegWriteM", bus.RegWriteM, 0);
    check("reset store WriteDataM", bus.WriteDataM, 0);
    check("reset store RdE", bus.RdE, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage RISC-V pipeline. It registers decode-stage operands and control, including the 3-bit ALU control from the ALU decoder, into the ID/EX register. It applies hazard-unit forwarding, performs the ALU operation, resolves branches and jumps, and registers results into the EX/MEM register for the memory stage.

## Interface
Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- FlushE  in  1  loads a bubble into ID/EX on the next edge.
- RD1D, RD2D  in  XLEN  register-file read data.
- PCD, PCPlus4D, ImmExtD  in  XLEN  PC, PC+4, sign-extended immediate.
- Rs1D, Rs2D, RdD  in  5  register indices.
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1  control bits.
- ResultSrcD  in  2  writeback select: 00 ALU, 01 memory, 10 PC+4.
- ALUControlD  in  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ForwardAE, ForwardBE  in  2  operand select: 00 register, 10 ALUResultM, 01 ResultW.
- ResultW  in  XLEN  writeback-stage result.
- Rs1E, Rs2E, RdE  out  5  registered indices for the hazard unit.
- ResultSrcE0  out  1  ResultSrcE[0]; load-use detection.
- PCSrcE  out  1  redirect fetch.
- PCTargetE  out  XLEN  branch/jump target.
- RegWriteM, MemWriteM  out  1  registered control.
- ResultSrcM  out  2  registered writeback select.
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN  registered results.
- RdM  out  5  registered destination.

## Operation
- ID/EX register captures every D-suffixed input on each clock edge (no stall input).
- EX-stage combinational logic:
  - SrcAE is RD1E, ALUResultM, or ResultW per ForwardAE. Select 11 behaves as 00.
  - WriteDataE is chosen the same way from RD2E per ForwardBE.
  - SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU, on XLEN bits, modulo 2^XLEN, no overflow flag:
  - add: SrcA+SrcB.
  - sub: SrcA−SrcB.
  - and, or: bitwise.
  - slt: signed SrcA<SrcB gives 1, else 0, zero-extended.
  - Codes 100, 110, 111 give result 0.
- ZeroE = (ALUResultE == 0).
- PCSrcE = JumpE | (BranchE & ZeroE). Only beq is supported; funct3 is not carried.
- PCTargetE = PCE + ImmExtE, wrapping.
- EX/MEM register captures RegWriteE, MemWriteE, ResultSrcE, ALUResultE, WriteDataE, RdE, PCPlus4E on each edge. It has no flush.
- Forwarding from ALUResultM uses this block's own EX/MEM output, one cycle old.

## Timing
- Reset, synchronous:
  - ID/EX and EX/MEM fields all clear to 0, data included.
  - All outputs read 0 after the first reset edge.
  - PCTargetE reads 0 because PCE and ImmExtE are 0.
- Priority: reset > FlushE > normal capture.
- Bubble:
  - RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, and ALUControlE become 0.
  - Rs1E, Rs2E, RdE become 0.
  - Data fields become 0.
  - A bubble therefore executes add 0+0, produces PCSrcE=0, and writes nothing.
- Latency:
  - Inputs presented before edge N appear on E outputs after edge N.
  - The same instruction appears on M outputs after edge N+1.
- PCSrcE and PCTargetE are combinational from ID/EX and forwarding inputs, valid within the same cycle. The hazard unit uses PCSrcE to assert FlushE and FlushD.
- FlushE asserted together with PCSrcE=1:
  - The branch in EX still completes to EX/MEM on the edge.
  - Only the incoming instruction is squashed.
- Reset mid-stream: both in-flight instructions are discarded; no partial writes reach M.

## Structure
- Shared package riscv_pkg holds:
  - alu_ctrl_t enum: ADD=000, SUB=001, AND=010, OR=011, SLT=101.
  - fwd_sel_t enum: REG=00, WB=01, MEM=10.
  - result_src_t enum: ALU=00, MEM=01, PC4=10.
  - XLEN default.
- The ALU decoder uses the same alu_ctrl_t, so encodings stay in one place.
- One sub-module: alu (SrcA, SrcB, ALUControl → Result, Zero), purely combinational.
- Pipeline registers are inline in execute_stage.

## Test plan
- Reset then idle → after one edge every output is 0, PCSrcE=0.
- add, no forwarding: RD1D=5, RD2D=7, ALUSrcD=0, ALUControlD=000, RdD=3, RegWriteD=1 → after edge N ALU result is 12 internally; after edge N+1 ALUResultM=12, RdM=3, RegWriteM=1.
- sub and slt with negatives: SrcA=0xFFFFFFFE, SrcB=1:
  - sub gives ALUResultM=0xFFFFFFFD.
  - slt gives 1.
  - SrcA=1, SrcB=0xFFFFFFFE under slt gives 0.
- Forwarding:
  - Back-to-back add x1=10; add x2=x1+x1 with ForwardAE=ForwardBE=10 → second ALUResultM=20.
  - The same with ForwardAE=01, ResultW=4, RD1D stale=99 → SrcA uses 4.
- Branch: BranchD=1, ALUControlD=001, RD1D=RD2D=8, PCD=0x100, ImmExtD=0x20 → PCSrcE=1, PCTargetE=0x120.
  - Operands 8/9 → PCSrcE=0.
  - JumpD=1 → PCSrcE=1 regardless.
- Flush and priority:
  - FlushE=1 with RegWriteD=1, MemWriteD=1 → E and later M control all 0.
  - reset and FlushE together → all zeros.
  - Reset asserted with a store in EX → MemWriteM=0 after the edge.
